cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Eight-phase instruction sequencer for the 8-bit RISC CPU. It sits directly upstream of the ALU and the accumulator. It steps each instruction through fetch, decode, operand fetch and execute, and decodes the 3-bit opcode from the instruction register into the datapath control strobes. It drives the ALU clock-enable, the accumulator/IR/PC load strobes and the memory read/write controls, and it stops the machine on HLT.

## Interface
- No parameters. The phase count (8) and opcode encoding are fixed constants.
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- opcd  in  3  opcode field from instruction register; valid from phase 3 onward
- zero  in  1  ALU zero status; sampled in phase 6
- mem_rdy  in  1  memory ready; gates leaving phases 2 and 6
- sel  out  1  address mux: 1 selects PC, 0 selects IR operand address
- rd  out  1  memory read enable
- wr  out  1  memory write strobe
- ld_ir  out  1  instruction register load
- inc_pc  out  1  program counter increment
- ld_pc  out  1  program counter load (jump)
- ld_ac  out  1  accumulator load from ALU output
- alu_en  out  1  ALU clock-enable, one cycle, operands valid
- data_e  out  1  accumulator drives memory data bus
- halt  out  1  machine halted, sticky
- phase  out  3  current phase, for debug and bench

## Operation
- Opcodes: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP. ALUOP is the set ADD, AND, XOR, LDA.
- Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE. The phase counter advances by 1 per cycle and wraps from 7 to 0.
- Strobe decode (phase, opcd, zero, halted):
  - sel: phases 0–3.
  - rd: phases 1–3; also phases 5–7 when ALUOP.
  - ld_ir: phases 2–3.
  - inc_pc: phase 4; also phase 6 when SKZ and zero=1.
  - alu_en: phase 5 when ALUOP.
  - ld_ac: phase 7 when ALUOP.
  - ld_pc: phases 6–7 when JMP.
  - data_e: phases 6–7 when STO.
  - wr: phase 7 when STO.
- HLT: in phase 3 with opcd=000, the halted flag sets at the clock edge ending phase 3. Once halted:
  - phase freezes at 4.
  - halt=1.
  - every other strobe is forced to 0.
  - The flag is cleared only by rst.
- Wait states: in phase 2 or 6 with mem_rdy=0, the phase holds and the strobes of that phase stay asserted. The phase advances on the first cycle with mem_rdy=1.
- In phase 6, zero is sampled on each cycle of the stall; inc_pc follows the current value.
- SKZ with zero=0, and HLT before it halts, behave as NOP for the remaining phases.

## Timing
- Reset: the synchronous rst edge sets phase=0 and clears halted. In the cycle after reset, outputs are sel=1 and all other strobes 0, with halt=0 and phase=0.
- Strobes are a combinational decode of the registered phase/halted state plus opcd and zero. No output depends on mem_rdy.
- An instruction with no wait states takes 8 cycles. Each wait cycle in phase 2 or 6 adds one cycle.
- halt rises in the first cycle of what would be phase 4, which is 4 cycles after the start of phase 0.
- rst overrides everything, including mid-instruction, a mem_rdy stall, or the halted state. Phase 0 follows on the next cycle and no partial strobes are issued.
- opcd is ignored in phases 0–2. The bench drives it as X there.

## Structure
- A shared package `cpu_pkg` holds:
  - opcode localparams (OP_HLT … OP_JMP).
  - phase localparams (PH_INST_ADDR … PH_STORE).
  - an `is_aluop` function.
- The ALU uses the same package for its opcode case.
- One sub-module, `cpu_decode`, is natural: a purely combinational strobe decoder (phase, opcd, zero, halted → strobes). The top level keeps the phase counter, the halted flag and the mem_rdy stall logic.

## Test plan
- Reset then ADD with mem_rdy=1:
  - phase runs 0..7..0.
  - sel=1 in cycles 0–3, ld_ir in 2–3, inc_pc in 4, alu_en in 5, ld_ac in 7, rd in 1–3 and 5–7.
- STO: data_e=1 in phases 6–7, wr=1 only in phase 7, rd=0 in phases 5–7, ld_ac never asserted.
- SKZ:
  - with zero=1, inc_pc pulses in phases 4 and 6, giving 2 increments.
  - with zero=0, only phase 4.
- JMP: ld_pc=1 in phases 6–7. Hold mem_rdy=0 for 3 cycles in phase 6 → phase reads 6 for 4 cycles and the instruction completes in 11 cycles.
- HLT: halt=1 from cycle 4 onward, phase stuck at 4, all strobes 0 for 20 cycles. rst → phase 0, halt 0.
- Assert rst in phase 5 of an ADD → no ld_ac pulse, and the next cycle shows phase 0 with sel=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode/phase definitions for the 8-bit RISC CPU sequencer and ALU.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    typedef struct packed {
        logic sel;
        logic rd;
        logic wr;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic alu_en;
        logic data_e;
        logic halt;
    } strobes_t;

    function automatic logic is_aluop(input opcode_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Datapath-facing bus of the sequencer: status inputs and control strobes.
interface cpu_sequencer_if;

    logic [2:0] opcd;
    logic       zero;
    logic       mem_rdy;
    logic       sel;
    logic       rd;
    logic       wr;
    logic       ld_ir;
    logic       inc_pc;
    logic       ld_pc;
    logic       ld_ac;
    logic       alu_en;
    logic       data_e;
    logic       halt;
    logic [2:0] phase;

    modport master (
        output opcd, zero, mem_rdy,
        input  sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, alu_en, data_e, halt, phase
    );

    modport slave (
        input  opcd, zero, mem_rdy,
        output sel, rd, wr, ld_ir, inc_pc, ld_pc, ld_ac, alu_en, data_e, halt, phase
    );

endinterface

// File: rtl/cpu_decode.sv
// Combinational strobe decoder: (phase, opcode, zero, halted) -> control strobes.
module cpu_decode
    import cpu_pkg::*;
(
    input  phase_e     phase,
    input  logic [2:0] opcd,
    input  logic       zero,
    input  logic       halted,
    output strobes_t   strb
);

    opcode_e op;
    logic    aluop;

    assign op    = opcode_e'(opcd);
    assign aluop = is_aluop(op);

    // Phases 0-3 never look at opcd, which is not yet valid there.
    always_comb begin
        strb = '0;
        if (!halted) begin
            unique case (phase)
                PH_INST_ADDR: begin
                    strb.sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    strb.sel = 1'b1;
                    strb.rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    strb.sel   = 1'b1;
                    strb.rd    = 1'b1;
                    strb.ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    strb.inc_pc = 1'b1;
                end
                PH_OP_FETCH: begin
                    strb.rd     = aluop;
                    strb.alu_en = aluop;
                end
                PH_ALU_OP: begin
                    strb.rd     = aluop;
                    strb.inc_pc = (op == OP_SKZ) && zero;
                    strb.ld_pc  = (op == OP_JMP);
                    strb.data_e = (op == OP_STO);
                end
                PH_STORE: begin
                    strb.rd     = aluop;
                    strb.ld_ac  = aluop;
                    strb.ld_pc  = (op == OP_JMP);
                    strb.data_e = (op == OP_STO);
                    strb.wr     = (op == OP_STO);
                end
                default: strb = '0;
            endcase
        end
        strb.halt = halted;
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Eight-phase instruction sequencer: phase counter, sticky halt flag, memory wait states.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.slave  bus
);

    phase_e   phase_q, phase_d;
    logic     halted_q, halted_d;
    strobes_t strb;

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (phase_q == PH_IDLE && bus.opcd == OP_HLT) begin
                // Halting still steps into phase 4, where the counter then freezes.
                halted_d = 1'b1;
                phase_d  = PH_OP_ADDR;
            end else if ((phase_q == PH_INST_LOAD || phase_q == PH_ALU_OP) && !bus.mem_rdy) begin
                phase_d = phase_q;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    cpu_decode u_decode (
        .phase  (phase_q),
        .opcd   (bus.opcd),
        .zero   (bus.zero),
        .halted (halted_q),
        .strb   (strb)
    );

    assign bus.sel    = strb.sel;
    assign bus.rd     = strb.rd;
    assign bus.wr     = strb.wr;
    assign bus.ld_ir  = strb.ld_ir;
    assign bus.inc_pc = strb.inc_pc;
    assign bus.ld_pc  = strb.ld_pc;
    assign bus.ld_ac  = strb.ld_ac;
    assign bus.alu_en = strb.alu_en;
    assign bus.data_e = strb.data_e;
    assign bus.halt   = strb.halt;
    assign bus.phase  = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-phase strobe vectors checked against hand-written tables.
module tb_cpu_sequencer;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND_ = 3'd3,
                           XOR_ = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    cpu_sequencer_if bus ();

    cpu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Vector order: sel rd wr ld_ir inc_pc ld_pc ld_ac alu_en data_e halt
    function automatic logic [9:0] strobe_vec();
        return {bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.inc_pc,
                bus.ld_pc, bus.ld_ac, bus.alu_en, bus.data_e, bus.halt};
    endfunction

    function automatic logic [9:0] exp_vec(input logic [2:0] op, input int p, input logic z);
        logic alu;
        alu = (op == ADD) || (op == AND_) || (op == XOR_) || (op == LDA);
        case (p)
            0: return 10'b1000000000;
            1: return 10'b1100000000;
            2: return 10'b1101000000;
            3: return 10'b1101000000;
            4: return 10'b0000100000;
            5: return alu ? 10'b0100000100 : 10'b0000000000;
            6: begin
                if (alu)                return 10'b0100000000;
                if (op == SKZ && z)     return 10'b0000100000;
                if (op == JMP)          return 10'b0000010000;
                if (op == STO)          return 10'b0000000010;
                return 10'b0000000000;
            end
            default: begin
                if (alu)                return 10'b0100001000;
                if (op == JMP)          return 10'b0000010000;
                if (op == STO)          return 10'b0010000010;
                return 10'b0000000000;
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_state(input string tag, input int p, input logic [9:0] ev);
        chk({tag, "_phase"}, {29'b0, bus.phase}, p);
        chk({tag, "_strb"}, {22'b0, strobe_vec()}, {22'b0, ev});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs phases 0..last of one instruction; st2/st6 are wait cycles in phases 2/6.
    task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                             input int st2, input int st6, input int last);
        for (int p = 0; p <= last; p++) begin
            int n;
            n = (p == 2) ? st2 : (p == 6) ? st6 : 0;
            for (int w = 0; w <= n; w++) begin
                bus.opcd    = (p < 3) ? 3'bxxx : op;
                bus.zero    = z;
                bus.mem_rdy = (w == n);
                #1;
                check_state($sformatf("%s_p%0d_w%0d", tag, p, w), p, exp_vec(op, p, z));
                tick();
            end
        end
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        total       = 0;
        bad         = 0;
        bus.opcd    = 3'b000;
        bus.zero    = 1'b0;
        bus.mem_rdy = 1'b1;

        tick();
        rst = 1'b0;
        #1;
        check_state("reset", 0, 10'b1000000000);

        run_instr("add",   ADD,  1'b0, 0, 0, 7);
        run_instr("sto",   STO,  1'b0, 0, 0, 7);
        run_instr("skz1",  SKZ,  1'b1, 0, 0, 7);
        run_instr("skz0",  SKZ,  1'b0, 0, 0, 7);
        run_instr("jmp",   JMP,  1'b0, 0, 3, 7);
        run_instr("and",   AND_, 1'b1, 2, 0, 7);
        run_instr("xor",   XOR_, 1'b0, 0, 1, 7);
        run_instr("lda",   LDA,  1'b0, 0, 0, 7);
        #1;
        check_state("after_lda", 0, 10'b1000000000);

        // SKZ stall in phase 6 with zero changing: inc_pc tracks current zero
        run_instr("skzst", SKZ, 1'b0, 0, 0, 5);
        bus.opcd = SKZ; bus.mem_rdy = 1'b0; bus.zero = 1'b0;
        #1; check_state("skzst_z0", 6, 10'b0000000000);
        bus.zero = 1'b1;
        #1; check_state("skzst_z1", 6, 10'b0000100000);
        tick();
        bus.mem_rdy = 1'b1; bus.zero = 1'b1;
        #1; check_state("skzst_go", 6, 10'b0000100000);
        tick();
        bus.zero = 1'b0;
        #1; check_state("skzst_p7", 7, 10'b0000000000);
        tick();

        // Reset in phase 5 of an ADD
        run_instr("addrst", ADD, 1'b0, 0, 0, 4);
        bus.opcd = ADD;
        #1; check_state("addrst_p5", 5, 10'b0100000100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1; check_state("addrst_after", 0, 10'b1000000000);
        run_instr("add2", ADD, 1'b0, 0, 0, 7);

        // HLT: halted from the cycle after phase 3, frozen for 20 cycles
        run_instr("hlt", HLT, 1'b0, 0, 0, 3);
        for (int c = 0; c < 20; c++) begin
            bus.opcd    = c[2:0];
            bus.zero    = c[0];
            bus.mem_rdy = c[1];
            #1;
            check_state($sformatf("halted_c%0d", c), 4, 10'b0000000001);
            tick();
        end
        bus.mem_rdy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_rdy = 1'b1;
        #1; check_state("hlt_rst", 0, 10'b1000000000);
        run_instr("add3", ADD, 1'b0, 0, 0, 7);

        // Reset during a phase-2 stall
        run_instr("stall2", XOR_, 1'b0, 0, 0, 1);
        bus.mem_rdy = 1'b0;
        #1; check_state("stall2_p2", 2, 10'b1101000000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1; check_state("stall2_rst", 0, 10'b1000000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
